// File: rtl/cpu_gen2_if.sv
// Memory bus between the cpu_gen2 core (master) and its memory (slave).
interface cpu_gen2_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 12
);
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cpu_gen2.sv
// Accumulator CPU: fetch / decode / memory FSM with wait-state tolerant bus.
// Bus outputs are registered from the next state so they are glitch-free.
module cpu_gen2 #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resume,
  cpu_gen2_if.master        bus,
  output logic              halt,
  output logic [AWIDTH-1:0] pc_out,
  output logic [DWIDTH-1:0] ac_out,
  output logic              carry
);

  generate
    if (DWIDTH != AWIDTH + 4) begin : g_width_check
      $error("cpu_gen2: DWIDTH must equal AWIDTH+4");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_START,
    ST_IF,
    ST_DEC,
    ST_MEM,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_HLT = 4'd0;
  localparam logic [3:0] OP_SKZ = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LDA = 4'd5;
  localparam logic [3:0] OP_STO = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8;
  localparam logic [3:0] OP_SKC = 4'd9;
  localparam logic [3:0] OP_LDI = 4'd10;
  localparam logic [3:0] OP_OR  = 4'd11;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] ac_q, ac_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic              carry_q, carry_d;
  logic              halt_q, halt_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [3:0]        opcode_q, opcode_d;
  logic [AWIDTH-1:0] operand_q, operand_d;
  logic [DWIDTH:0]   add_sum;

  assign opcode_q  = ir_q[DWIDTH-1:AWIDTH];
  assign operand_q = ir_q[AWIDTH-1:0];
  assign opcode_d  = ir_d[DWIDTH-1:AWIDTH];
  assign operand_d = ir_d[AWIDTH-1:0];
  assign add_sum   = {1'b0, ac_q} + {1'b0, bus.mem_rdata};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    ir_d    = ir_q;
    carry_d = carry_q;

    unique case (state_q)
      ST_START: state_d = ST_IF;

      ST_IF: begin
        if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = ST_DEC;
        end
      end

      ST_DEC: begin
        state_d = ST_IF;
        case (opcode_q)
          OP_HLT: state_d = ST_HALT;
          OP_SKZ: if (ac_q == '0) pc_d = pc_q + 1'b1;
          OP_SKC: if (carry_q) pc_d = pc_q + 1'b1;
          OP_JMP: pc_d = operand_q;
          OP_LDI: ac_d = {{(DWIDTH-AWIDTH){1'b0}}, operand_q};
          OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_OR, OP_LDA, OP_STO:
            state_d = ST_MEM;
          default: state_d = ST_IF;
        endcase
      end

      ST_MEM: begin
        if (bus.mem_ready) begin
          state_d = ST_IF;
          case (opcode_q)
            OP_ADD: {carry_d, ac_d} = add_sum;
            OP_SUB: begin
              ac_d    = ac_q - bus.mem_rdata;
              carry_d = (ac_q >= bus.mem_rdata);
            end
            OP_AND: ac_d = ac_q & bus.mem_rdata;
            OP_XOR: ac_d = ac_q ^ bus.mem_rdata;
            OP_OR:  ac_d = ac_q | bus.mem_rdata;
            OP_LDA: ac_d = bus.mem_rdata;
            default: ac_d = ac_q;
          endcase
        end
      end

      ST_HALT: if (resume) state_d = ST_IF;

      default: state_d = ST_START;
    endcase
  end

  // Bus strobes and address are derived from where the FSM is heading next.
  always_comb begin
    mem_rd_d   = (state_d == ST_IF) || ((state_d == ST_MEM) && (opcode_d != OP_STO));
    mem_wr_d   = (state_d == ST_MEM) && (opcode_d == OP_STO);
    mem_addr_d = (state_d == ST_MEM) ? operand_d : pc_d;
    halt_d     = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_START;
      pc_q       <= '0;
      ac_q       <= '0;
      ir_q       <= '0;
      carry_q    <= 1'b0;
      halt_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ac_q       <= ac_d;
      ir_q       <= ir_d;
      carry_q    <= carry_d;
      halt_q     <= halt_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = ac_q;
  assign halt          = halt_q;
  assign pc_out        = pc_q;
  assign ac_out        = ac_q;
  assign carry         = carry_q;

endmodule

// File: tb/tb_cpu_gen2.sv
// Directed bench for cpu_gen2: behavioural memory with programmable wait states,
// hand-assembled programs and hand-computed expected results.
module tb_cpu_gen2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        resume = 1'b0;
  logic        halt;
  logic [7:0]  pc_out;
  logic [11:0] ac_out;
  logic        carry;

  logic [11:0] mem [256];
  int          wait_states = 0;
  int          wait_cnt = 0;
  logic        stray_ready = 1'b0;
  int          overlap_cnt = 0;

  int          compare_cnt = 0;
  int          mismatch_cnt = 0;

  logic [7:0]  fetch_log [4];
  int          fetch_cnt;

  cpu_gen2_if #(.AWIDTH(8), .DWIDTH(12)) bus ();

  cpu_gen2 #(.AWIDTH(8), .DWIDTH(12)) dut (
    .clk    (clk),
    .rst    (rst),
    .resume (resume),
    .bus    (bus),
    .halt   (halt),
    .pc_out (pc_out),
    .ac_out (ac_out),
    .carry  (carry)
  );

  always #5 clk = ~clk;

  // Memory responds on the falling edge so the core sees stable ready/data.
  always @(negedge clk) begin
    if (rst && (bus.mem_rd || bus.mem_wr)) begin
      if (wait_cnt < wait_states) begin
        bus.mem_ready = 1'b0;
        wait_cnt++;
      end else begin
        bus.mem_ready = 1'b1;
        wait_cnt = 0;
        if (bus.mem_rd) bus.mem_rdata = mem[bus.mem_addr];
        else mem[bus.mem_addr] = bus.mem_wdata;
      end
    end else begin
      bus.mem_ready = stray_ready;
      wait_cnt = 0;
    end
    if (bus.mem_rd && bus.mem_wr) overlap_cnt++;
  end

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_and_clear();
    tick();
    rst = 1'b0;
    resume = 1'b0;
    stray_ready = 1'b0;
    wait_states = 0;
    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
    tick();
  endtask

  task automatic wait_halt(input int limit, output int n);
    n = 0;
    while (!halt && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic capture_fetches(input int want, input int limit);
    fetch_cnt = 0;
    for (int i = 0; i < limit && fetch_cnt < want; i++) begin
      tick();
      if (bus.mem_rd && bus.mem_ready) begin
        fetch_log[fetch_cnt] = bus.mem_addr;
        fetch_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    compare_cnt++;
    if ({pc_out, ac_out, carry, halt} !== 22'h0) begin
      mismatch_cnt++;
      $display("[TB] FAIL reset_regs: got pc=%h ac=%h c=%b h=%b, expected all zero", pc_out, ac_out, carry, halt);
    end
    compare_cnt++;
    if ({bus.mem_rd, bus.mem_wr, bus.mem_addr} !== 10'h0) begin
      mismatch_cnt++;
      $display("[TB] FAIL reset_bus: got rd=%b wr=%b addr=%h, expected 0/0/00", bus.mem_rd, bus.mem_wr, bus.mem_addr);
    end
  endtask

  task automatic test_basic();
    int n;
    reset_and_clear();
    mem[8'h00] = 12'h510;
    mem[8'h01] = 12'h211;
    mem[8'h02] = 12'h612;
    mem[8'h03] = 12'h000;
    mem[8'h10] = 12'h005;
    mem[8'h11] = 12'h007;
    rst = 1'b1;
    compare_cnt++;
    if (bus.mem_rd !== 1'b0) begin
      mismatch_cnt++;
      $display("[TB] FAIL start_no_read: got rd=%b, expected 0", bus.mem_rd);
    end
    tick();
    compare_cnt++;
    if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 8'h00}) begin
      mismatch_cnt++;
      $display("[TB] FAIL first_fetch: got rd=%b addr=%h, expected 1/00", bus.mem_rd, bus.mem_addr);
    end
    wait_halt(40, n);
    compare_cnt++;
    if (n !== 11) begin
      mismatch_cnt++;
      $display("[TB] FAIL basic_halt_cycle: got %0d, expected 11", n);
    end
    compare_cnt++;
    if (mem[8'h12] !== 12'h00C) begin
      mismatch_cnt++;
      $display("[TB] FAIL basic_store: got %h, expected 00c", mem[8'h12]);
    end
    compare_cnt++;
    if ({pc_out, ac_out, carry} !== {8'h04, 12'h00C, 1'b0}) begin
      mismatch_cnt++;
      $display("[TB] FAIL basic_regs: got pc=%h ac=%h c=%b, expected 04/00c/0", pc_out, ac_out, carry);
    end
  endtask

  task automatic test_carry_skip();
    int n;
    reset_and_clear();
    mem[8'h00] = 12'h520;
    mem[8'h01] = 12'h221;
    mem[8'h02] = 12'h900;
    mem[8'h03] = 12'hA55;
    mem[8'h04] = 12'h100;
    mem[8'h05] = 12'hA66;
    mem[8'h06] = 12'h000;
    mem[8'h20] = 12'hFFF;
    mem[8'h21] = 12'h001;
    rst = 1'b1;
    wait_halt(60, n);
    compare_cnt++;
    if ({halt, pc_out, ac_out, carry} !== {1'b1, 8'h07, 12'h000, 1'b1}) begin
      mismatch_cnt++;
      $display("[TB] FAIL carry_skip: got h=%b pc=%h ac=%h c=%b, expected 1/07/000/1", halt, pc_out, ac_out, carry);
    end
  endtask

  task automatic test_logic_ops();
    int n;
    reset_and_clear();
    mem[8'h00] = 12'hAFF;
    mem[8'h01] = 12'h244;
    mem[8'h02] = 12'h540;
    mem[8'h03] = 12'h341;
    mem[8'h04] = 12'hB42;
    mem[8'h05] = 12'h443;
    mem[8'h06] = 12'h000;
    mem[8'h40] = 12'h0F0;
    mem[8'h41] = 12'h3C3;
    mem[8'h42] = 12'h005;
    mem[8'h43] = 12'h0FF;
    mem[8'h44] = 12'hF01;
    rst = 1'b1;
    wait_halt(60, n);
    compare_cnt++;
    if ({halt, pc_out, ac_out} !== {1'b1, 8'h07, 12'h03A}) begin
      mismatch_cnt++;
      $display("[TB] FAIL logic_ops: got h=%b pc=%h ac=%h, expected 1/07/03a", halt, pc_out, ac_out);
    end
    compare_cnt++;
    if (carry !== 1'b1) begin
      mismatch_cnt++;
      $display("[TB] FAIL logic_keeps_carry: got %b, expected 1", carry);
    end
  endtask

  task automatic test_sub_borrow();
    int n;
    reset_and_clear();
    mem[8'h00] = 12'hA03;
    mem[8'h01] = 12'h830;
    mem[8'h02] = 12'h000;
    mem[8'h03] = 12'hA05;
    mem[8'h04] = 12'h830;
    mem[8'h05] = 12'h000;
    mem[8'h30] = 12'h005;
    rst = 1'b1;
    wait_halt(40, n);
    compare_cnt++;
    if ({halt, pc_out, ac_out, carry} !== {1'b1, 8'h03, 12'hFFE, 1'b0}) begin
      mismatch_cnt++;
      $display("[TB] FAIL sub_borrow: got h=%b pc=%h ac=%h c=%b, expected 1/03/ffe/0", halt, pc_out, ac_out, carry);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    wait_halt(40, n);
    compare_cnt++;
    if ({halt, pc_out, ac_out, carry} !== {1'b1, 8'h06, 12'h000, 1'b1}) begin
      mismatch_cnt++;
      $display("[TB] FAIL sub_equal: got h=%b pc=%h ac=%h c=%b, expected 1/06/000/1", halt, pc_out, ac_out, carry);
    end
  endtask

  task automatic test_wait_states();
    int n;
    int bad;
    reset_and_clear();
    mem[8'h00] = 12'h510;
    mem[8'h01] = 12'h000;
    mem[8'h10] = 12'h123;
    wait_states = 3;
    rst = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if ({bus.mem_rd, bus.mem_wr, bus.mem_addr} !== {2'b10, 8'h00}) bad++;
      tick();
    end
    if ({bus.mem_rd, bus.mem_wr} !== 2'b00) bad++;
    tick();
    for (int i = 0; i < 4; i++) begin
      if ({bus.mem_rd, bus.mem_wr, bus.mem_addr} !== {2'b10, 8'h10}) bad++;
      tick();
    end
    compare_cnt++;
    if (bad !== 0) begin
      mismatch_cnt++;
      $display("[TB] FAIL wait_stable: got %0d unstable cycles, expected 0", bad);
    end
    compare_cnt++;
    if ({bus.mem_rd, bus.mem_addr, ac_out} !== {1'b1, 8'h01, 12'h123}) begin
      mismatch_cnt++;
      $display("[TB] FAIL wait_latency: got rd=%b addr=%h ac=%h, expected 1/01/123 at cycle 9", bus.mem_rd, bus.mem_addr, ac_out);
    end
    wait_halt(40, n);
    compare_cnt++;
    if (halt !== 1'b1) begin
      mismatch_cnt++;
      $display("[TB] FAIL wait_halt: got %b, expected 1", halt);
    end
  endtask

  task automatic test_wrap_jump();
    int n;
    reset_and_clear();
    mem[8'h00] = 12'h7FF;
    mem[8'hFF] = 12'hC00;
    rst = 1'b1;
    capture_fetches(3, 30);
    compare_cnt++;
    if ({fetch_cnt[7:0], fetch_log[0], fetch_log[1], fetch_log[2]} !== {8'd3, 8'h00, 8'hFF, 8'h00}) begin
      mismatch_cnt++;
      $display("[TB] FAIL jmp_wrap: got n=%0d %h %h %h, expected 3 00 ff 00", fetch_cnt, fetch_log[0], fetch_log[1], fetch_log[2]);
    end
    reset_and_clear();
    mem[8'h00] = 12'h7FF;
    mem[8'hFF] = 12'h100;
    mem[8'h01] = 12'h000;
    mem[8'h02] = 12'hA99;
    rst = 1'b1;
    capture_fetches(3, 30);
    compare_cnt++;
    if ({fetch_cnt[7:0], fetch_log[0], fetch_log[1], fetch_log[2]} !== {8'd3, 8'h00, 8'hFF, 8'h01}) begin
      mismatch_cnt++;
      $display("[TB] FAIL skz_wrap: got n=%0d %h %h %h, expected 3 00 ff 01", fetch_cnt, fetch_log[0], fetch_log[1], fetch_log[2]);
    end
    wait_halt(20, n);
    compare_cnt++;
    if ({halt, pc_out} !== {1'b1, 8'h02}) begin
      mismatch_cnt++;
      $display("[TB] FAIL skz_wrap_halt: got h=%b pc=%h, expected 1/02", halt, pc_out);
    end
  endtask

  task automatic test_halt_reset();
    int n;
    int activity;
    reset_and_clear();
    mem[8'h00] = 12'h000;
    mem[8'h01] = 12'hA77;
    mem[8'h02] = 12'h650;
    rst = 1'b1;
    wait_halt(20, n);
    stray_ready = 1'b1;
    activity = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.mem_rd || bus.mem_wr || !halt || pc_out != 8'h01) activity++;
    end
    stray_ready = 1'b0;
    compare_cnt++;
    if (activity !== 0) begin
      mismatch_cnt++;
      $display("[TB] FAIL halt_idle: got %0d active cycles, expected 0", activity);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    compare_cnt++;
    if ({halt, bus.mem_rd, bus.mem_addr} !== {1'b0, 1'b1, 8'h01}) begin
      mismatch_cnt++;
      $display("[TB] FAIL resume_fetch: got h=%b rd=%b addr=%h, expected 0/1/01", halt, bus.mem_rd, bus.mem_addr);
    end
    wait_states = 3;
    n = 0;
    while (!bus.mem_wr && n < 40) begin
      tick();
      n++;
    end
    compare_cnt++;
    if ({bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h50, 12'h077}) begin
      mismatch_cnt++;
      $display("[TB] FAIL sto_request: got wr=%b addr=%h wdata=%h, expected 1/50/077", bus.mem_wr, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    #2 rst = 1'b0;
    #1;
    compare_cnt++;
    if ({bus.mem_wr, bus.mem_rd, bus.mem_addr, ac_out, pc_out, halt} !== 31'h0) begin
      mismatch_cnt++;
      $display("[TB] FAIL reset_mid_sto: got wr=%b rd=%b addr=%h ac=%h pc=%h h=%b, expected all zero", bus.mem_wr, bus.mem_rd, bus.mem_addr, ac_out, pc_out, halt);
    end
    tick();
    compare_cnt++;
    if (mem[8'h50] !== 12'h000) begin
      mismatch_cnt++;
      $display("[TB] FAIL sto_abandoned: got %h, expected 000", mem[8'h50]);
    end
  endtask

  task automatic test_bus_exclusive();
    compare_cnt++;
    if (overlap_cnt !== 0) begin
      mismatch_cnt++;
      $display("[TB] FAIL rd_wr_overlap: got %0d cycles, expected 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_skip();
    test_logic_ops();
    test_sub_borrow();
    test_wait_states();
    test_wrap_jump();
    test_halt_reset();
    test_bus_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_gen2.md
CPU_GEN2 -- requirements
Module: cpu_gen2

Interface
REQ-001 Parameter AWIDTH, default 8: address width; the instruction address field and the PC are AWIDTH bits.
REQ-002 Parameter DWIDTH, default 12: data and instruction width; DWIDTH SHALL equal AWIDTH+4, checked at elaboration.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 resume  input  1  one-cycle pulse that leaves HALT.
REQ-006 mem_rdata  input  DWIDTH  read data, valid in the cycle mem_ready=1.
REQ-007 mem_ready  input  1  access-complete strobe from memory.
REQ-008 mem_addr  output  AWIDTH  memory address.
REQ-009 mem_rd  output  1  read request, held until mem_ready.
REQ-010 mem_wr  output  1  write request, held until mem_ready.
REQ-011 mem_wdata  output  DWIDTH  write data, always equal to AC.
REQ-012 halt  output  1  high while in HALT.
REQ-013 pc_out  output  AWIDTH  current PC.
REQ-014 ac_out  output  DWIDTH  current accumulator.
REQ-015 carry  output  1  carry flag.

Function
REQ-016 Instruction format SHALL be opcode = bits[DWIDTH-1:AWIDTH], operand address A = bits[AWIDTH-1:0].
REQ-017 Opcodes SHALL be: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP, 8 SUB, 9 SKC, 10 LDI, 11 OR, 12-15 NOP.
REQ-018 FSM states SHALL be START, IF, DEC, MEM, HALT; reset enters START; START always goes to IF on the next edge.
REQ-019 IF: mem_rd=1, mem_addr=PC, wait while mem_ready=0; on mem_ready=1, IR<=mem_rdata, PC<=PC+1 mod 2^AWIDTH, then DEC.
REQ-020 DEC, non-memory ops, one cycle, then IF: SKZ PC+=1 if AC==0; SKC PC+=1 if carry=1; JMP PC<=A; LDI AC<=zero-extended A; NOP no change; HLT goes to HALT instead of IF.
REQ-021 DEC for ADD, SUB, AND, XOR, OR, LDA, STO SHALL go to MEM.
REQ-022 MEM read ops: mem_rd=1, mem_addr=A, wait; on mem_ready=1 apply the op, then IF.
REQ-023 MEM read-op results: AC<=AC op mem_rdata; LDA AC<=mem_rdata.
REQ-024 MEM STO: mem_wr=1, mem_addr=A, mem_wdata=AC; on mem_ready=1 go to IF with AC unchanged.
REQ-025 Arithmetic SHALL be modulo 2^DWIDTH.
REQ-026 ADD SHALL set carry = carry-out; SUB SHALL set carry=1 when AC >= operand (no borrow), else 0.
REQ-027 AND, XOR, OR, LDA, LDI, STO SHALL leave carry unchanged.
REQ-028 Latency with mem_ready tied high: 2 cycles for non-memory ops, 3 cycles for memory ops; each memory wait cycle adds exactly one cycle.
REQ-029 mem_rd and mem_wr SHALL never be high together, and both SHALL be 0 in START, DEC, HALT.
REQ-030 mem_addr SHALL equal PC in START, DEC and HALT.
REQ-031 HALT: halt=1, no memory access, PC/AC/carry frozen.
REQ-032 resume=1 in HALT SHALL go to IF on the next edge; resume SHALL be ignored in all other states.
REQ-033 PC increment and SKZ/SKC skip SHALL wrap 2^AWIDTH-1 -> 0.
REQ-034 mem_ready while no request is pending SHALL be ignored.

Reset
REQ-035 rst=0 SHALL asynchronously force START, PC=0, AC=0, IR=0, carry=0, halt=0, mem_rd=0, mem_wr=0, mem_addr=0.
REQ-036 Reset SHALL take effect mid-access, including during a wait state; the pending access is abandoned.
REQ-037 After rst deasserts, the first mem_rd SHALL be issued at address 0 one cycle later (START -> IF).

Verification
REQ-038 Scenario, basic program (AWIDTH=8, mem_ready=1): program 0:LDA 0x10, 1:ADD 0x11, 2:STO 0x12, 3:HLT with mem[0x10]=0x005, mem[0x11]=0x007 -> mem[0x12]=0x00C; halt=1 at cycle 11 after START; pc_out=4.
REQ-039 Scenario, add carry and SKC: AC=0xFFF, ADD of 0x001 -> AC=0x000, carry=1; a following SKC skips the next instruction and a following SKZ also skips.
REQ-040 Scenario, SUB borrow: AC=0x003, SUB of 0x005 -> AC=0xFFE, carry=0; AC=0x005, SUB of 0x005 -> AC=0, carry=1.
REQ-041 Scenario, wait states: mem_ready low for 3 cycles on every access -> LDA takes 9 cycles; mem_rd and mem_addr stable throughout each wait.
REQ-042 Scenario, wrap and jump: JMP 0xFF, with 0xFF holding NOP -> next fetch at 0x00; SKZ at 0xFF with AC=0 -> next fetch at 0x01.
REQ-043 Scenario, halt and reset: during HALT, resume=0 for 5 cycles gives no bus activity; a resume pulse gives a fetch at PC; rst=0 asserted during an STO wait gives mem_wr=0 immediately and AC=0.
